fila_escrita_reg: RTL and testbench
===================================

// Module: fila_escrita_reg
// PURPOSE
// - Write-back queue: the writer side of the 64x32 register file's write port (end_escrita/dados_escrita/EscreveReg).
// - Buffers results from two producers (ULA, memory load path), accepts up to two per cycle and issues one register write per cycle.
// - Provides a lookup of pending writes so decode can detect and forward values not yet in the register file.
// PARAMETERS
// - PROFUNDIDADE   4   queue entries; power of 2, >= 2
// - LARGURA_DADOS  32  data width
// - LARGURA_END    6   register address width (64 registers)
// PORTS
// - clock          in   1   single clock, all state on posedge
// - reset_n        in   1   synchronous active-low reset
// - mem_valido     in   1   memory-path write request
// - mem_end        in   6   memory-path destination register
// - mem_dados      in   32  memory-path data
// - mem_pronto     out  1   memory-path request accepted this cycle if mem_valido
// - ula_valido     in   1   ULA write request
// - ula_end        in   6   ULA destination register
// - ula_dados      in   32  ULA data
// - ula_pronto     out  1   ULA request accepted this cycle if ula_valido
// - end_escrita    out  6   register-file write address (registered)
// - dados_escrita  out  32  register-file write data (registered)
// - EscreveReg     out  1   register-file write enable (registered)
// - end_consulta1/2 in  6   decode lookup addresses
// - pendente1/2    out  1   a write to end_consultaN is queued or on the output stage
// - dado_pend1/2   out  32  newest pending data for end_consultaN (0 if not pending)
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): count, pointers, EscreveReg, end_escrita, dados_escrita <= 0; queued entries discarded; *_pronto forced 0 while reset_n=0.
// - livres = PROFUNDIDADE - count (registered count; a same-cycle pop gives no credit).
// - mem_pronto = livres>=1. ula_pronto = livres>=2, or livres>=1 and !mem_valido. Memory path has priority.
// - Both accepted in one cycle: memory entry enqueued before ULA entry (older).
// - Handshake with end=0 completes but nothing is enqueued (register 0 stays zero); it consumes no slot.
// - Pop: at each posedge with count>0, head entry moves to output regs, EscreveReg<=1; else EscreveReg<=0. One pop per cycle max.
// - count_next = count + pushes - pop; never exceeds PROFUNDIDADE, never underflows.
// - Latency: accepted at edge k into empty queue -> EscreveReg=1 during cycle k+1..k+2, written by register file at edge k+2.
// - Lookup (combinational): match across valid queue entries and output stage (when EscreveReg=1); dado_pend = data of youngest match; address 0 never pending.
// - Entry leaves lookup visibility on the edge the register file writes it (value then readable from the register file).
// - Pointers wrap modulo PROFUNDIDADE.
// CONFIGURATION
// - FILA_ESCRITA_BYPASS_EN defined: when count=0 at the edge, the single accepted request (memory priority; if both, memory bypasses and ULA is enqueued) loads the output regs directly; latency drops to 1 cycle (EscreveReg=1 in cycle after acceptance edge). Writes to r0 never bypass.
// - Undefined: all writes pass through the queue; latency 2 cycles as above.
// TESTING
// - Reset: reset_n=0 2 cycles with mem_valido=ula_valido=1 -> EscreveReg=0, mem_pronto=ula_pronto=0, nothing written after release.
// - Single: ula r5=0xDEADBEEF into empty queue -> EscreveReg=1,end_escrita=5 for exactly one cycle, 2 cycles after accept (1 with BYPASS_EN); pendente1(5)=1 until that write edge.
// - Dual/fill (PROFUNDIDADE=4): mem+ula valid every cycle, r1..r8 -> writes issued in order mem,ula,mem,...; ula_pronto drops when livres<2; no entry lost or duplicated.
// - r0: mem r0=0x55 -> mem_pronto=1, count unchanged, no EscreveReg pulse, pendente(0)=0.
// - Forward: r7=1 then r7=2 queued -> pendente=1, dado_pend=2; after both drain, pendente=0.
// - Reset mid-drain: 3 entries queued, reset_n=0 one cycle -> EscreveReg=0 next cycle, count=0, no stale writes.

Source files
------------

// File: rtl/fila_escrita_reg.sv
// Write-back queue feeding the register file write port from the memory and ULA producers,
// with pending-write lookup for decode. Optional output bypass on an empty queue: FILA_ESCRITA_BYPASS_EN.
module fila_escrita_reg #(
  parameter int PROFUNDIDADE  = 4,
  parameter int LARGURA_DADOS = 32,
  parameter int LARGURA_END   = 6
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     mem_valido,
  input  logic [LARGURA_END-1:0]   mem_end,
  input  logic [LARGURA_DADOS-1:0] mem_dados,
  output logic                     mem_pronto,
  input  logic                     ula_valido,
  input  logic [LARGURA_END-1:0]   ula_end,
  input  logic [LARGURA_DADOS-1:0] ula_dados,
  output logic                     ula_pronto,
  output logic [LARGURA_END-1:0]   end_escrita,
  output logic [LARGURA_DADOS-1:0] dados_escrita,
  output logic                     EscreveReg,
  input  logic [LARGURA_END-1:0]   end_consulta1,
  input  logic [LARGURA_END-1:0]   end_consulta2,
  output logic                     pendente1,
  output logic                     pendente2,
  output logic [LARGURA_DADOS-1:0] dado_pend1,
  output logic [LARGURA_DADOS-1:0] dado_pend2
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  // Handshake: a request transfers at a posedge where valido=1 and pronto=1.
  // pronto depends only on registered count and mem_valido, never on the popped slot.
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [LARGURA_END-1:0]   fila_end_q   [PROFUNDIDADE];
  logic [LARGURA_DADOS-1:0] fila_dados_q [PROFUNDIDADE];
  logic [LARGURA_END-1:0]   end_escrita_q, end_escrita_d;
  logic [LARGURA_DADOS-1:0] dados_escrita_q, dados_escrita_d;
  logic                     escreve_q, escreve_d;

  logic [CW-1:0] livres;
  logic          mem_push, ula_push, pop;
  logic          byp_mem, byp_ula;
  logic          enq_mem, enq_ula;
  logic [CW-1:0] n_enq;
  logic [PW-1:0] slot_ula;

  assign livres     = CW'(PROFUNDIDADE) - count_q;
  assign mem_pronto = reset_n && (livres >= CW'(1));
  assign ula_pronto = reset_n && ((livres >= CW'(2)) || ((livres >= CW'(1)) && !mem_valido));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign mem_push = mem_valido && mem_pronto && (mem_end != '0);
  assign ula_push = ula_valido && ula_pronto && (ula_end != '0);
  assign pop      = (count_q != '0);

`ifdef FILA_ESCRITA_BYPASS_EN
  assign byp_mem = (count_q == '0) && mem_push;
  assign byp_ula = (count_q == '0) && !mem_push && ula_push;
`else
  assign byp_mem = 1'b0;
  assign byp_ula = 1'b0;
`endif

  assign enq_mem  = mem_push && !byp_mem;
  assign enq_ula  = ula_push && !byp_ula;
  assign n_enq    = CW'(enq_mem) + CW'(enq_ula);
  assign slot_ula = enq_mem ? tail_q + PW'(1) : tail_q;

  always_comb begin
    count_d         = count_q + n_enq - CW'(pop);
    head_d          = pop ? head_q + PW'(1) : head_q;
    tail_d          = tail_q + PW'(n_enq);
    escreve_d       = 1'b0;
    end_escrita_d   = end_escrita_q;
    dados_escrita_d = dados_escrita_q;
    if (pop) begin
      escreve_d       = 1'b1;
      end_escrita_d   = fila_end_q[head_q];
      dados_escrita_d = fila_dados_q[head_q];
    end else if (byp_mem) begin
      escreve_d       = 1'b1;
      end_escrita_d   = mem_end;
      dados_escrita_d = mem_dados;
    end else if (byp_ula) begin
      escreve_d       = 1'b1;
      end_escrita_d   = ula_end;
      dados_escrita_d = ula_dados;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      escreve_q       <= 1'b0;
      end_escrita_q   <= '0;
      dados_escrita_q <= '0;
    end else begin
      count_q         <= count_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      escreve_q       <= escreve_d;
      end_escrita_q   <= end_escrita_d;
      dados_escrita_q <= dados_escrita_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count/head alone.
  always_ff @(posedge clock) begin
    if (reset_n && enq_mem) begin
      fila_end_q[tail_q]   <= mem_end;
      fila_dados_q[tail_q] <= mem_dados;
    end
    if (reset_n && enq_ula) begin
      fila_end_q[slot_ula]   <= ula_end;
      fila_dados_q[slot_ula] <= ula_dados;
    end
  end

  // Output stage is the oldest pending write; later queue slots override it.
  function automatic logic [LARGURA_DADOS:0] consulta(input logic [LARGURA_END-1:0] addr);
    logic                     hit;
    logic [LARGURA_DADOS-1:0] dado;
    logic [PW-1:0]            idx;
    hit  = 1'b0;
    dado = '0;
    if (escreve_q && (end_escrita_q == addr)) begin
      hit  = 1'b1;
      dado = dados_escrita_q;
    end
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (fila_end_q[idx] == addr)) begin
        hit  = 1'b1;
        dado = fila_dados_q[idx];
      end
    end
    if (addr == '0) begin
      hit  = 1'b0;
      dado = '0;
    end
    return {hit, dado};
  endfunction

  logic [LARGURA_DADOS:0] res1, res2;

  always_comb begin
    res1 = consulta(end_consulta1);
    res2 = consulta(end_consulta2);
  end

  assign pendente1     = res1[LARGURA_DADOS];
  assign dado_pend1    = res1[LARGURA_DADOS-1:0];
  assign pendente2     = res2[LARGURA_DADOS];
  assign dado_pend2    = res2[LARGURA_DADOS-1:0];
  assign end_escrita   = end_escrita_q;
  assign dados_escrita = dados_escrita_q;
  assign EscreveReg    = escreve_q;

endmodule

// File: tb/tb_fila_escrita_reg.sv
// Directed bench for fila_escrita_reg: reset, single write latency, dual fill, r0, forwarding, reset mid-drain.
module tb_fila_escrita_reg;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        mem_valido, ula_valido;
  logic [5:0]  mem_end, ula_end;
  logic [31:0] mem_dados, ula_dados;
  logic        mem_pronto, ula_pronto;
  logic [5:0]  end_escrita;
  logic [31:0] dados_escrita;
  logic        EscreveReg;
  logic [5:0]  end_consulta1, end_consulta2;
  logic        pendente1, pendente2;
  logic [31:0] dado_pend1, dado_pend2;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];

  always #5 clock = ~clock;

  fila_escrita_reg dut (
    .clock(clock), .reset_n(reset_n),
    .mem_valido(mem_valido), .mem_end(mem_end), .mem_dados(mem_dados), .mem_pronto(mem_pronto),
    .ula_valido(ula_valido), .ula_end(ula_end), .ula_dados(ula_dados), .ula_pronto(ula_pronto),
    .end_escrita(end_escrita), .dados_escrita(dados_escrita), .EscreveReg(EscreveReg),
    .end_consulta1(end_consulta1), .end_consulta2(end_consulta2),
    .pendente1(pendente1), .pendente2(pendente2),
    .dado_pend1(dado_pend1), .dado_pend2(dado_pend2)
  );

  // Scoreboard: every cycle with EscreveReg=1 is one register-file write.
  always @(negedge clock) begin
    if (EscreveReg === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got end=%0d dados=%h required no write", end_escrita, dados_escrita);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        if ({end_escrita, dados_escrita} !== e) begin
          errors++;
          $display("FAIL write_order got end=%0d dados=%h required end=%0d dados=%h",
                   end_escrita, dados_escrita, e[37:32], e[31:0]);
        end
      end
    end
  end

  task tick();
    @(posedge clock);
    #1;
  endtask

  task idle();
    mem_valido = 1'b0;
    ula_valido = 1'b0;
    mem_end    = '0;
    ula_end    = '0;
    mem_dados  = '0;
    ula_dados  = '0;
  endtask

  task drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout got %0d left required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task test_reset();
    reset_n = 1'b0;
    mem_valido = 1'b1; mem_end = 6'd3; mem_dados = 32'h33;
    ula_valido = 1'b1; ula_end = 6'd4; ula_dados = 32'h44;
    end_consulta1 = 6'd3; end_consulta2 = 6'd4;
    #1;
    checks++;
    if ({mem_pronto, ula_pronto} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pronto got %b required 00", {mem_pronto, ula_pronto});
    end
    tick();
    tick();
    checks++;
    if (EscreveReg !== 1'b0) begin
      errors++;
      $display("FAIL reset_escreve got %b required 0", EscreveReg);
    end
    checks++;
    if ({end_escrita, dados_escrita} !== 38'd0) begin
      errors++;
      $display("FAIL reset_out_regs got end=%0d dados=%h required 0", end_escrita, dados_escrita);
    end
    checks++;
    if ({pendente1, pendente2} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pendente got %b required 00", {pendente1, pendente2});
    end
    idle();
    reset_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (EscreveReg !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_escreve got %b required 0", EscreveReg);
    end
  endtask

  task test_single();
    ula_valido = 1'b1; ula_end = 6'd5; ula_dados = 32'hDEADBEEF;
    end_consulta1 = 6'd5;
    #1;
    checks++;
    if (ula_pronto !== 1'b1) begin
      errors++;
      $display("FAIL single_pronto got %b required 1", ula_pronto);
    end
    exp_q.push_back({6'd5, 32'hDEADBEEF});
    tick();
    idle();
    #1;
`ifdef FILA_ESCRITA_BYPASS_EN
    checks++;
    if ({EscreveReg, end_escrita, pendente1, dado_pend1} !== {1'b1, 6'd5, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_c1 got we=%b end=%0d pend=%b dado=%h required 1 5 1 deadbeef",
               EscreveReg, end_escrita, pendente1, dado_pend1);
    end
`else
    checks++;
    if ({EscreveReg, pendente1, dado_pend1} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_c1 got we=%b pend=%b dado=%h required 0 1 deadbeef",
               EscreveReg, pendente1, dado_pend1);
    end
    tick();
    checks++;
    if ({EscreveReg, end_escrita, dados_escrita, pendente1} !== {1'b1, 6'd5, 32'hDEADBEEF, 1'b1}) begin
      errors++;
      $display("FAIL single_c2 got we=%b end=%0d dados=%h pend=%b required 1 5 deadbeef 1",
               EscreveReg, end_escrita, dados_escrita, pendente1);
    end
`endif
    tick();
    checks++;
    if ({EscreveReg, pendente1, dado_pend1} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL single_after got we=%b pend=%b dado=%h required 0 0 0",
               EscreveReg, pendente1, dado_pend1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_count got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task test_dual_fill();
    int  mi, ui, cnt_m, livres, pushes;
    bit  exp_mp, exp_up, macc, uacc, saw_drop;
    mi = 0; ui = 0; cnt_m = 0; saw_drop = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (mi >= 4 && ui >= 4) break;
      mem_valido = (mi < 4); mem_end = 6'(2 * mi + 1); mem_dados = 32'h1000 + 32'(2 * mi + 1);
      ula_valido = (ui < 4); ula_end = 6'(2 * ui + 2); ula_dados = 32'h1000 + 32'(2 * ui + 2);
      #1;
      livres = 4 - cnt_m;
      exp_mp = (livres >= 1);
      exp_up = (livres >= 2) || ((livres >= 1) && !mem_valido);
      checks++;
      if ({mem_pronto, ula_pronto} !== {exp_mp, exp_up}) begin
        errors++;
        $display("FAIL dual_pronto cyc=%0d got %b required %b", cyc, {mem_pronto, ula_pronto}, {exp_mp, exp_up});
      end
      macc = mem_valido && exp_mp;
      uacc = ula_valido && exp_up;
      if (mem_valido && ula_valido && !exp_up) saw_drop = 1'b1;
      if (macc) begin exp_q.push_back({mem_end, mem_dados}); mi++; end
      if (uacc) begin exp_q.push_back({ula_end, ula_dados}); ui++; end
      pushes = int'(macc) + int'(uacc);
`ifdef FILA_ESCRITA_BYPASS_EN
      if (cnt_m == 0 && pushes > 0) pushes--;
`endif
      cnt_m = cnt_m + pushes - ((cnt_m > 0) ? 1 : 0);
      tick();
    end
    idle();
    checks++;
    if (saw_drop !== 1'b1 || mi != 4 || ui != 4) begin
      errors++;
      $display("FAIL dual_progress got drop=%b mem=%0d ula=%0d required 1 4 4", saw_drop, mi, ui);
    end
    drain("dual");
  endtask

  task test_r0();
    mem_valido = 1'b1; mem_end = 6'd0; mem_dados = 32'h55;
    end_consulta1 = 6'd0;
    #1;
    checks++;
    if (mem_pronto !== 1'b1) begin
      errors++;
      $display("FAIL r0_pronto got %b required 1", mem_pronto);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({pendente1, dado_pend1} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL r0_pendente got %b %h required 0 0", pendente1, dado_pend1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (EscreveReg !== 1'b0) begin
        errors++;
        $display("FAIL r0_no_write cyc=%0d got %b required 0", i, EscreveReg);
      end
      tick();
    end
  endtask

  task test_forward();
    mem_valido = 1'b1; mem_end = 6'd7; mem_dados = 32'd1;
    ula_valido = 1'b1; ula_end = 6'd7; ula_dados = 32'd2;
    end_consulta1 = 6'd7; end_consulta2 = 6'd7;
    exp_q.push_back({6'd7, 32'd1});
    exp_q.push_back({6'd7, 32'd2});
    tick();
    idle();
    #1;
    checks++;
    if ({pendente1, dado_pend1, pendente2, dado_pend2} !== {1'b1, 32'd2, 1'b1, 32'd2}) begin
      errors++;
      $display("FAIL fwd_youngest got %b %h %b %h required 1 2 1 2", pendente1, dado_pend1, pendente2, dado_pend2);
    end
    tick();
    checks++;
    if ({pendente1, dado_pend1} !== {1'b1, 32'd2}) begin
      errors++;
      $display("FAIL fwd_mid got %b %h required 1 2", pendente1, dado_pend1);
    end
    drain("fwd");
    checks++;
    if ({pendente1, dado_pend1, pendente2} !== {1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL fwd_after got %b %h %b required 0 0 0", pendente1, dado_pend1, pendente2);
    end
  endtask

  task test_reset_mid();
    mem_valido = 1'b1; mem_end = 6'd10; mem_dados = 32'hA;
    ula_valido = 1'b1; ula_end = 6'd11; ula_dados = 32'hB;
    end_consulta1 = 6'd12; end_consulta2 = 6'd11;
    exp_q.push_back({6'd10, 32'hA});
`ifdef FILA_ESCRITA_BYPASS_EN
    exp_q.push_back({6'd11, 32'hB});
`endif
    tick();
    idle();
    mem_valido = 1'b1; mem_end = 6'd12; mem_dados = 32'hC;
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_pronto, ula_pronto} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_pronto got %b required 00", {mem_pronto, ula_pronto});
    end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({EscreveReg, pendente1, pendente2} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_cleared got we=%b p1=%b p2=%b required 000", EscreveReg, pendente1, pendente2);
    end
    mem_valido = 1'b1; ula_valido = 1'b1;
    #1;
    checks++;
    if ({mem_pronto, ula_pronto} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_empty got %b required 11", {mem_pronto, ula_pronto});
    end
    idle();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_writes got %0d missing required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    end_consulta1 = '0;
    end_consulta2 = '0;
    test_reset();
    test_single();
    test_dual_fill();
    test_r0();
    test_forward();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

endmodule
